// File: rtl/packet_tx_pkg.sv
// Shared packet-link definitions: framing constants, response codes and tx state encoding.
package packet_tx_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned PKT_MAX_PAYLOAD = 16;
    localparam int unsigned LEN_W           = 5;

    localparam logic [BYTE_W-1:0] PKT_SYNC_BYTE = 8'h55;
    localparam logic [BYTE_W-1:0] PKT_CHK_INIT  = 8'h00;
    localparam logic [BYTE_W-1:0] RSP_ERROR     = 8'h80;
    localparam logic [BYTE_W-1:0] RSP_OK        = 8'h81;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4
    } tx_state_t;

    // Payload length as carried on the wire: requested length limited to the buffer size.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [BYTE_W-1:0] len);
        return (len > BYTE_W'(PKT_MAX_PAYLOAD)) ? LEN_W'(PKT_MAX_PAYLOAD) : len[LEN_W-1:0];
    endfunction

endpackage

// File: rtl/packet_tx.sv
// Packet transmitter: captures a response packet and streams SYNC, LEN, payload, XOR checksum
// one byte at a time over a valid/ready handshake to the UART byte transmitter.
module packet_tx
    import packet_tx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = PKT_SYNC_BYTE,
    parameter logic [7:0] CHK_INIT  = PKT_CHK_INIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_packet_wr,
    input  logic [7:0] tx_payload_len,
    input  logic [7:0] tx_buf0,
    input  logic [7:0] tx_buf1,
    input  logic [7:0] tx_buf2,
    input  logic [7:0] tx_buf3,
    input  logic [7:0] tx_buf4,
    input  logic [7:0] tx_buf5,
    input  logic [7:0] tx_buf6,
    input  logic [7:0] tx_buf7,
    input  logic [7:0] tx_buf8,
    input  logic [7:0] tx_buf9,
    input  logic [7:0] tx_buf10,
    input  logic [7:0] tx_buf11,
    input  logic [7:0] tx_buf12,
    input  logic [7:0] tx_buf13,
    input  logic [7:0] tx_buf14,
    input  logic [7:0] tx_buf15,
    output logic       tx_done,
    output logic       tx_busy,
    output logic       tx_overrun,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    input  logic       tx_byte_ready
);

    logic [BYTE_W-1:0] buf_in [PKT_MAX_PAYLOAD];
    logic [BYTE_W-1:0] buf_q  [PKT_MAX_PAYLOAD];
    logic [BYTE_W-1:0] buf_d  [PKT_MAX_PAYLOAD];

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic [BYTE_W-1:0] byte_d;
    logic              valid_d, busy_d, done_d, overrun_d;
    logic              hs_c;
    logic [BYTE_W-1:0] cur_byte_c;

    assign buf_in[0]  = tx_buf0;
    assign buf_in[1]  = tx_buf1;
    assign buf_in[2]  = tx_buf2;
    assign buf_in[3]  = tx_buf3;
    assign buf_in[4]  = tx_buf4;
    assign buf_in[5]  = tx_buf5;
    assign buf_in[6]  = tx_buf6;
    assign buf_in[7]  = tx_buf7;
    assign buf_in[8]  = tx_buf8;
    assign buf_in[9]  = tx_buf9;
    assign buf_in[10] = tx_buf10;
    assign buf_in[11] = tx_buf11;
    assign buf_in[12] = tx_buf12;
    assign buf_in[13] = tx_buf13;
    assign buf_in[14] = tx_buf14;
    assign buf_in[15] = tx_buf15;

    assign hs_c       = tx_byte_valid & tx_byte_ready;
    assign cur_byte_c = buf_q[idx_q[3:0]];

    // Next-state and next-output logic; every output register is loaded with the byte it presents next.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        buf_d     = buf_q;
        byte_d    = tx_byte;
        valid_d   = tx_byte_valid;
        busy_d    = tx_busy;
        done_d    = 1'b0;
        overrun_d = tx_overrun;

        if (tx_packet_wr && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_packet_wr) begin
                    len_d   = clamp_len(tx_payload_len);
                    buf_d   = buf_in;
                    idx_d   = '0;
                    chk_d   = CHK_INIT;
                    state_d = S_SYNC;
                    byte_d  = SYNC_BYTE;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SYNC: begin
                if (hs_c) begin
                    state_d = S_LEN;
                    byte_d  = BYTE_W'(len_q);
                end
            end
            S_LEN: begin
                if (hs_c) begin
                    chk_d = chk_q ^ BYTE_W'(len_q);
                    if (len_q != '0) begin
                        state_d = S_PAYLOAD;
                        byte_d  = buf_q[0];
                    end else begin
                        state_d = S_CHK;
                        byte_d  = chk_q ^ BYTE_W'(len_q);
                    end
                end
            end
            S_PAYLOAD: begin
                if (hs_c) begin
                    chk_d = chk_q ^ cur_byte_c;
                    if (idx_q == (len_q - LEN_W'(1))) begin
                        state_d = S_CHK;
                        byte_d  = chk_q ^ cur_byte_c;
                    end else begin
                        idx_d  = idx_q + LEN_W'(1);
                        byte_d = buf_q[idx_q[3:0] + 4'd1];
                    end
                end
            end
            S_CHK: begin
                if (hs_c) begin
                    state_d = S_IDLE;
                    byte_d  = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            chk_q         <= '0;
            tx_byte       <= '0;
            tx_byte_valid <= 1'b0;
            tx_busy       <= 1'b0;
            tx_done       <= 1'b0;
            tx_overrun    <= 1'b0;
            for (int i = 0; i < int'(PKT_MAX_PAYLOAD); i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            chk_q         <= chk_d;
            buf_q         <= buf_d;
            tx_byte       <= byte_d;
            tx_byte_valid <= valid_d;
            tx_busy       <= busy_d;
            tx_done       <= done_d;
            tx_overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_packet_tx.sv
// Bench for packet_tx: directed and randomized frames checked against a frame-level reference model.
module tb_packet_tx;

    typedef logic [7:0] byteq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_packet_wr;
    logic [7:0] tx_payload_len;
    logic [7:0] tb_buf [16];
    logic       tx_done, tx_busy, tx_overrun, tx_byte_valid;
    logic [7:0] tx_byte;
    logic       tx_byte_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    packet_tx dut (
        .clk(clk), .rst(rst),
        .tx_packet_wr(tx_packet_wr), .tx_payload_len(tx_payload_len),
        .tx_buf0(tb_buf[0]),   .tx_buf1(tb_buf[1]),   .tx_buf2(tb_buf[2]),   .tx_buf3(tb_buf[3]),
        .tx_buf4(tb_buf[4]),   .tx_buf5(tb_buf[5]),   .tx_buf6(tb_buf[6]),   .tx_buf7(tb_buf[7]),
        .tx_buf8(tb_buf[8]),   .tx_buf9(tb_buf[9]),   .tx_buf10(tb_buf[10]), .tx_buf11(tb_buf[11]),
        .tx_buf12(tb_buf[12]), .tx_buf13(tb_buf[13]), .tx_buf14(tb_buf[14]), .tx_buf15(tb_buf[15]),
        .tx_done(tx_done), .tx_busy(tx_busy), .tx_overrun(tx_overrun),
        .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid), .tx_byte_ready(tx_byte_ready)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected wire bytes for a requested length and buffer.
    function automatic byteq_t build_frame(input int len, input logic [7:0] b [16]);
        byteq_t q;
        int eff;
        logic [7:0] chk;
        eff = (len > 16) ? 16 : len;
        chk = 8'h00 ^ 8'(eff);
        q.push_back(8'h55);
        q.push_back(8'(eff));
        for (int i = 0; i < eff; i++) begin
            q.push_back(b[i]);
            chk ^= b[i];
        end
        q.push_back(chk);
        return q;
    endfunction

    task automatic randomize_buf(output logic [7:0] b [16]);
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom);
    endtask

    // Sends one frame from the current negedge; ovr_at >= 0 fires a stray wr when byte ovr_at is on the wire.
    // With chain set, returns in the tx_done cycle so the caller can start the next frame there.
    task automatic run_frame(input string name, input int len, input logic [7:0] b [16],
                             input bit rnd_ready, input int ovr_at, input bit chain);
        byteq_t exp;
        logic [7:0] junk [16];
        int k;
        int cyc;
        bit fired;
        exp = build_frame(len, b);
        tx_packet_wr   = 1'b1;
        tx_payload_len = 8'(len);
        tb_buf         = b;
        tx_byte_ready  = rnd_ready ? 1'($urandom) : 1'b1;
        tick();
        tx_packet_wr = 1'b0;
        randomize_buf(junk);
        tb_buf = junk;
        tx_payload_len = 8'($urandom);
        k = 0;
        cyc = 0;
        fired = 1'b0;
        while (k < exp.size() && cyc < 400) begin
            check($sformatf("%s.valid%0d", name, k), 32'(tx_byte_valid), 32'd1);
            check($sformatf("%s.byte%0d", name, k), 32'(tx_byte), 32'(exp[k]));
            check($sformatf("%s.busy%0d", name, k), 32'(tx_busy), 32'd1);
            check($sformatf("%s.nodone%0d", name, k), 32'(tx_done), 32'd0);
            tx_byte_ready = rnd_ready ? 1'($urandom) : 1'b1;
            if (!fired && ovr_at >= 0 && k == ovr_at) begin
                tx_packet_wr   = 1'b1;
                tx_payload_len = 8'($urandom);
                fired = 1'b1;
            end
            if (tx_byte_ready) k++;
            tick();
            tx_packet_wr = 1'b0;
            cyc++;
        end
        if (k < exp.size()) check($sformatf("%s.timeout", name), 32'(k), 32'(exp.size()));
        check($sformatf("%s.done", name), 32'(tx_done), 32'd1);
        check($sformatf("%s.idle_busy", name), 32'(tx_busy), 32'd0);
        check($sformatf("%s.idle_valid", name), 32'(tx_byte_valid), 32'd0);
        if (ovr_at >= 0) check($sformatf("%s.overrun", name), 32'(tx_overrun), 32'd1);
        if (!chain) begin
            tx_byte_ready = 1'($urandom);
            tick();
            check($sformatf("%s.done_pulse", name), 32'(tx_done), 32'd0);
            check($sformatf("%s.post_valid", name), 32'(tx_byte_valid), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] b [16];
        rst            = 1'b1;
        tx_packet_wr   = 1'b0;
        tx_payload_len = 8'h00;
        tx_byte_ready  = 1'b0;
        for (int i = 0; i < 16; i++) tb_buf[i] = 8'h00;
        tick();
        tick();
        check("rst.valid", 32'(tx_byte_valid), 32'd0);
        check("rst.byte", 32'(tx_byte), 32'd0);
        check("rst.busy", 32'(tx_busy), 32'd0);
        check("rst.done", 32'(tx_done), 32'd0);
        check("rst.overrun", 32'(tx_overrun), 32'd0);
        rst = 1'b0;
        tx_byte_ready = 1'b1;
        repeat (3) begin
            tick();
            check("idle.valid", 32'(tx_byte_valid), 32'd0);
            check("idle.done", 32'(tx_done), 32'd0);
        end

        b = '{default: 8'h00};
        b[0] = 8'h81;
        run_frame("ok", 1, b, 1'b0, -1, 1'b0);

        randomize_buf(b);
        run_frame("zero", 0, b, 1'b0, -1, 1'b0);

        b = '{default: 8'h00};
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
        run_frame("bp", 3, b, 1'b1, -1, 1'b0);

        for (int i = 0; i < 16; i++) b[i] = 8'(i);
        run_frame("clamp", 20, b, 1'b1, -1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            randomize_buf(b);
            run_frame($sformatf("rnd%0d", n), int'($urandom_range(0, 24)), b, 1'b1, -1, 1'b0);
        end

        check("pre_ovr.overrun", 32'(tx_overrun), 32'd0);
        randomize_buf(b);
        run_frame("chain_a", 5, b, 1'b1, -1, 1'b1);
        randomize_buf(b);
        run_frame("chain_b", 16, b, 1'b0, -1, 1'b0);
        check("chain.overrun", 32'(tx_overrun), 32'd0);

        randomize_buf(b);
        run_frame("ovr", 8, b, 1'b1, 4, 1'b0);
        randomize_buf(b);
        run_frame("after_ovr", 2, b, 1'b1, -1, 1'b0);
        check("sticky.overrun", 32'(tx_overrun), 32'd1);

        randomize_buf(b);
        tx_packet_wr   = 1'b1;
        tx_payload_len = 8'd5;
        tb_buf         = b;
        tx_byte_ready  = 1'b1;
        tick();
        tx_packet_wr = 1'b0;
        repeat (3) tick();
        check("midrst.busy_before", 32'(tx_busy), 32'd1);
        check("midrst.byte_before", 32'(tx_byte), 32'(b[1]));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.valid", 32'(tx_byte_valid), 32'd0);
        check("midrst.byte", 32'(tx_byte), 32'd0);
        check("midrst.busy", 32'(tx_busy), 32'd0);
        check("midrst.done", 32'(tx_done), 32'd0);
        check("midrst.overrun", 32'(tx_overrun), 32'd0);
        repeat (4) begin
            tick();
            check("midrst.quiet_valid", 32'(tx_byte_valid), 32'd0);
            check("midrst.quiet_done", 32'(tx_done), 32'd0);
        end
        randomize_buf(b);
        run_frame("fresh", 7, b, 1'b1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
